// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg
// Shared definitions for the memory-mapped machine timer:
//   - word offsets of the register map (decoded from mem_addr[4:2])
//   - bit positions inside CTRL and STATUS
//   - byte_merge(): applies a 4-bit byte-enable mask to a 32-bit word
package mmio_timer_pkg;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_MTIME_LO = 3'd2;
    localparam logic [2:0] OFF_MTIME_HI = 3'd3;
    localparam logic [2:0] OFF_CMP_LO   = 3'd4;
    localparam logic [2:0] OFF_CMP_HI   = 3'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_DIV_LSB = 8;

    localparam int STATUS_PEND  = 0;

    // Lanes with wen set take the new byte, the others keep the old byte.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  wen
    );
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides the core clock down to the mtime tick rate.
// Ports:
//   CLK   in   core clock
//   RSTN  in   asynchronous active-low reset
//   en    in   counting enable; when low the counter is held at 0
//   div   in   divisor: one tick every div+1 cycles (div=0 -> every cycle)
//   tick  out  single-cycle pulse in the cycle the counter equals div
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] count;

    // Tick is combinational so mtime advances on the same edge the counter wraps.
    assign tick = en && (count == div);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder
// Memory-mapped machine timer responding on the LSU data bus.
// Ports:
//   CLK        in   core clock
//   RSTN       in   asynchronous active-low reset
//   mem_en     in   request valid (already qualified by address range)
//   mem_wen    in   byte write enables; 0 = read
//   mem_addr   in   byte address; only [4:2] decoded
//   mem_wdata  in   write data
//   mem_rdata  out  registered read data, held after the response
//   mem_rvld   out  one-cycle pulse, the cycle after a read is accepted
//   timer_irq  out  registered pending & CTRL.ie
module mmio_timer_responder
    import mmio_timer_pkg::*;
#(
    parameter int          PRESCALE_W = 8,
    parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_rvld,
    output logic        timer_irq
);

    logic                  ctrl_en;
    logic                  ctrl_ie;
    logic [PRESCALE_W-1:0] ctrl_div;
    logic                  pending;
    logic [63:0]           mtime;
    logic [31:0]           mtime_hi_shadow;
    logic [63:0]           mtimecmp;
    logic                  tick;

    logic [2:0]  offset;
    logic        rd_acc;
    logic        wr_acc;
    logic [31:0] live_word;
    logic [31:0] read_word;
    logic [31:0] wr_data;
    logic        status_clear;
    logic        cmp_hit;
    logic        unused_addr;

    assign offset      = mem_addr[4:2];
    assign unused_addr = ^{mem_addr[31:5], mem_addr[1:0]};
    assign rd_acc      = mem_en && (mem_wen == 4'b0000);
    assign wr_acc      = mem_en && (mem_wen != 4'b0000);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .CLK  (CLK),
        .RSTN (RSTN),
        .en   (ctrl_en),
        .div  (ctrl_div),
        .tick (tick)
    );

    // Live register contents; MTIME_HI here is the real counter so partial
    // writes merge against it, while reads of MTIME_HI use the shadow.
    always_comb begin
        live_word = '0;
        case (offset)
            OFF_CTRL: begin
                live_word[CTRL_EN]                       = ctrl_en;
                live_word[CTRL_IE]                       = ctrl_ie;
                live_word[CTRL_DIV_LSB +: PRESCALE_W]    = ctrl_div;
            end
            OFF_STATUS:   live_word[STATUS_PEND] = pending;
            OFF_MTIME_LO: live_word = mtime[31:0];
            OFF_MTIME_HI: live_word = mtime[63:32];
            OFF_CMP_LO:   live_word = mtimecmp[31:0];
            OFF_CMP_HI:   live_word = mtimecmp[63:32];
            default:      live_word = '0;
        endcase
    end

    assign read_word = (offset == OFF_MTIME_HI) ? mtime_hi_shadow : live_word;
    assign wr_data   = byte_merge(live_word, mem_wdata, mem_wen);

    // W1C looks at the raw lane so an unwritten byte 0 never clears the flag.
    assign status_clear = wr_acc && (offset == OFF_STATUS) &&
                          mem_wen[0] && mem_wdata[STATUS_PEND];
    assign cmp_hit      = (mtime >= mtimecmp);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ctrl_en  <= 1'b0;
            ctrl_ie  <= 1'b0;
            ctrl_div <= '0;
        end else if (wr_acc && (offset == OFF_CTRL)) begin
            ctrl_en  <= wr_data[CTRL_EN];
            ctrl_ie  <= wr_data[CTRL_IE];
            ctrl_div <= wr_data[CTRL_DIV_LSB +: PRESCALE_W];
        end
    end

    // A CPU write to either mtime word suppresses that cycle's increment.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mtime <= '0;
        end else if (wr_acc && (offset == OFF_MTIME_LO)) begin
            mtime[31:0] <= wr_data;
        end else if (wr_acc && (offset == OFF_MTIME_HI)) begin
            mtime[63:32] <= wr_data;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Reading the low word snapshots the high word for a tear-free 64-bit read.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mtime_hi_shadow <= '0;
        end else if (rd_acc && (offset == OFF_MTIME_LO)) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mtimecmp <= CMP_RESET;
        end else if (wr_acc && (offset == OFF_CMP_LO)) begin
            mtimecmp[31:0] <= wr_data;
        end else if (wr_acc && (offset == OFF_CMP_HI)) begin
            mtimecmp[63:32] <= wr_data;
        end
    end

    // Set has priority over W1C: software must move mtimecmp before clearing.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pending   <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            if (ctrl_en && cmp_hit) begin
                pending <= 1'b1;
            end else if (status_clear) begin
                pending <= 1'b0;
            end
            timer_irq <= pending && ctrl_ie;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mem_rdata <= '0;
            mem_rvld  <= 1'b0;
        end else begin
            mem_rvld <= rd_acc;
            if (rd_acc) begin
                mem_rdata <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// tb_mmio_timer_responder
// Directed bench for mmio_timer_responder. Reads push their expected data and
// response cycle into a queue; a monitor on the falling edge pops an entry for
// every mem_rvld pulse and compares. Interrupt timing is checked inline.
module tb_mmio_timer_responder;
    import mmio_timer_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        mem_en = 1'b0;
    logic [3:0]  mem_wen = 4'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_rvld;
    logic        timer_irq;

    typedef struct {
        logic [31:0] data;
        int          cycle;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    mmio_timer_responder dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rvld  (mem_rvld),
        .timer_irq (timer_irq)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RSTN && (mem_rvld !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_rvld: got rvld with rdata %08h, expected no response",
                         mem_rdata);
            end else begin
                e = exp_q.pop_front();
                check_output({e.name, "_data"}, mem_rdata, e.data);
                check_output({e.name, "_cycle"}, cyc, e.cycle);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic bus_read(input logic [2:0] off, input logic [31:0] expected,
                            input string name);
        exp_t e;
        mem_en    = 1'b1;
        mem_wen   = 4'b0000;
        mem_addr  = {27'd0, off, 2'b00};
        mem_wdata = '0;
        e.data    = expected;
        e.cycle   = cyc + 1;
        e.name    = name;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        mem_en = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [31:0] data,
                             input logic [3:0] wen);
        mem_en    = 1'b1;
        mem_wen   = wen;
        mem_addr  = {27'd0, off, 2'b00};
        mem_wdata = data;
        @(posedge CLK);
        #1;
        mem_en  = 1'b0;
        mem_wen = 4'b0000;
    endtask

    task automatic read_reset_map(input string tag);
        logic [31:0] reset_vals [8];
        reset_vals = '{32'h0, 32'h0, 32'h0, 32'h0,
                       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), reset_vals[i], $sformatf("%s_off%0d", tag, i));
        end
        idle(2);
    endtask

    initial begin
        // Reset state and back-to-back read of the whole map
        repeat (2) @(posedge CLK);
        #1;
        check_output("reset_rvld", {31'd0, mem_rvld}, 32'd0);
        check_output("reset_rdata", mem_rdata, 32'd0);
        check_output("reset_irq", {31'd0, timer_irq}, 32'd0);
        RSTN = 1'b1;
        idle(1);
        read_reset_map("rst");

        // Prescaler div=3: one increment every 4 cycles, then freeze
        bus_write(OFF_CTRL, 32'h0000_0301, 4'hF);
        for (int k = 0; k < 4; k++) begin
            bus_read(OFF_MTIME_LO, 32'(k), $sformatf("div3_rd%0d", k));
            if (k < 3) idle(3);
        end
        bus_write(OFF_CTRL, 32'h0, 4'hF);
        bus_read(OFF_MTIME_LO, 32'd3, "frozen_a");
        idle(4);
        bus_read(OFF_MTIME_LO, 32'd3, "frozen_b");

        // 32-bit carry and shadowed high word
        bus_write(OFF_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
        bus_write(OFF_MTIME_HI, 32'h0, 4'hF);
        bus_write(OFF_CTRL, 32'h1, 4'hF);
        idle(1);
        bus_write(OFF_CTRL, 32'h0, 4'hF);
        bus_read(OFF_MTIME_LO, 32'h0, "carry_lo");
        bus_read(OFF_MTIME_HI, 32'h1, "carry_hi");
        bus_write(OFF_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
        bus_write(OFF_MTIME_HI, 32'h0, 4'hF);
        bus_write(OFF_CTRL, 32'h1, 4'hF);
        idle(1);
        bus_read(OFF_MTIME_LO, 32'hFFFF_FFFF, "shadow_lo");
        bus_read(OFF_MTIME_HI, 32'h0, "shadow_hi_precarry");
        bus_write(OFF_CTRL, 32'h0, 4'hF);
        bus_read(OFF_MTIME_LO, 32'h2, "shadow_lo2");
        bus_read(OFF_MTIME_HI, 32'h1, "shadow_hi2");

        // Compare, pending, interrupt lag, set-wins W1C
        bus_write(OFF_MTIME_LO, 32'h0, 4'hF);
        bus_write(OFF_MTIME_HI, 32'h0, 4'hF);
        bus_write(OFF_CMP_HI, 32'h0, 4'hF);
        bus_write(OFF_CMP_LO, 32'd10, 4'hF);
        bus_write(OFF_CTRL, 32'h3, 4'hF);
        idle(10);
        check_output("irq_before_hit", {31'd0, timer_irq}, 32'd0);
        idle(1);
        check_output("irq_lag", {31'd0, timer_irq}, 32'd0);
        bus_read(OFF_STATUS, 32'h1, "pending_set");
        check_output("irq_set", {31'd0, timer_irq}, 32'd1);
        bus_write(OFF_STATUS, 32'h1, 4'hF);
        bus_read(OFF_STATUS, 32'h1, "w1c_set_wins");
        bus_write(OFF_CMP_LO, 32'd1000, 4'hF);
        bus_write(OFF_STATUS, 32'h1, 4'hF);
        check_output("irq_clear_lag", {31'd0, timer_irq}, 32'd1);
        idle(1);
        check_output("irq_cleared", {31'd0, timer_irq}, 32'd0);
        bus_read(OFF_STATUS, 32'h0, "pending_cleared");
        bus_write(OFF_CTRL, 32'h0, 4'hF);

        // Byte strobes, reserved offset, read data hold
        bus_write(OFF_CMP_LO, 32'hFFFF_FFFF, 4'hF);
        bus_write(OFF_CMP_LO, 32'hAABB_CCDD, 4'b0101);
        bus_read(OFF_CMP_LO, 32'hFFBB_FFDD, "byte_strobe");
        idle(3);
        check_output("rdata_hold", mem_rdata, 32'hFFBB_FFDD);
        bus_write(OFF_CTRL, 32'h0000_0500, 4'b0010);
        bus_read(OFF_CTRL, 32'h0000_0500, "ctrl_div_lane");
        bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd6, 32'h0, "reserved6");

        // Write beats tick in the same cycle
        bus_write(OFF_CTRL, 32'h1, 4'hF);
        idle(2);
        bus_write(OFF_MTIME_LO, 32'd5, 4'hF);
        bus_read(OFF_MTIME_LO, 32'd5, "write_beats_tick");

        // Reset with a read in flight: no response, everything back to reset
        mem_en   = 1'b1;
        mem_wen  = 4'b0000;
        mem_addr = {27'd0, OFF_MTIME_LO, 2'b00};
        @(posedge CLK);
        #1;
        mem_en = 1'b0;
        RSTN   = 1'b0;
        #1;
        check_output("midrst_rvld", {31'd0, mem_rvld}, 32'd0);
        check_output("midrst_rdata", mem_rdata, 32'd0);
        check_output("midrst_irq", {31'd0, timer_irq}, 32'd0);
        idle(2);
        RSTN = 1'b1;
        idle(1);
        read_reset_map("post_rst");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("[TB] FAIL missing_response: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
